// File: rtl/peripheral_spram_arbiter.sv
// peripheral_spram_arbiter
//   Shares one native SPRAM port between an instruction requester (m0) and a
//   data requester (m1). The winning command is registered onto the SPRAM
//   port; reads are tracked through a two-stage {valid, id} tag pipeline so
//   that read data returning two cycles after the grant is flagged to the
//   requester that issued it.
//
//   Optional feature (macro): PERIPHERAL_SPRAM_ARBITER_RR_EN
//     defined   - round-robin on a tie (winner is the one not granted last)
//     undefined - fixed priority, m1 wins every tie
//
//   Ports
//     HCLK, HRESET             clock (rising edge), async active-high reset
//     mX_req_i / mX_gnt_o      request / same-cycle grant (X = 0 instr, 1 data)
//     mX_we_i, mX_addr_i,
//     mX_be_i, mX_data_i       command fields, held until granted
//     mX_rvalid_o, mX_rdata_o  read return for requester X
//     req_o, we_o, addr_o,
//     be_o, data_o             registered SPRAM command
//     data_i                   SPRAM read data, one cycle after a read strobe
//
//   BE_WIDTH is derived from DATA_WIDTH and must not be overridden.

module peripheral_spram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,

  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [DATA_WIDTH-1:0] data_i
);

  logic                  last_id;
  logic                  win_id;
  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  s1_valid;
  logic                  s1_id;
  logic                  s2_valid;
  logic                  s2_id;

  // Arbitration: purely from the requests and last_id, no path from data_i.
  always_comb begin
    gnt_any = m0_req_i | m1_req_i;
`ifdef PERIPHERAL_SPRAM_ARBITER_RR_EN
    win_id  = (m0_req_i & m1_req_i) ? ~last_id : m1_req_i;
`else
    // m1 alone or in a tie wins; otherwise only m0 can be asking.
    win_id  = m1_req_i;
`endif
    m0_gnt_o = gnt_any & ~win_id;
    m1_gnt_o = gnt_any &  win_id;

    sel_we   = win_id ? m1_we_i   : m0_we_i;
    sel_addr = win_id ? m1_addr_i : m0_addr_i;
    sel_be   = win_id ? m1_be_i   : m0_be_i;
    sel_data = win_id ? m1_data_i : m0_data_i;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      req_o    <= 1'b0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      be_o     <= '0;
      data_o   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      req_o    <= gnt_any;
      s1_valid <= gnt_any & ~sel_we;
      s1_id    <= win_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      // Command fields hold their last value while idle.
      if (gnt_any) begin
        we_o    <= sel_we;
        addr_o  <= sel_addr;
        be_o    <= sel_be;
        data_o  <= sel_data;
        last_id <= win_id;
      end
    end
  end

  // Stage 2 lines up with data_i; rdata is shared and qualified by rvalid.
  always_comb begin
    m0_rvalid_o = s2_valid & ~s2_id;
    m1_rvalid_o = s2_valid &  s2_id;
    m0_rdata_o  = data_i;
    m1_rdata_o  = data_i;
  end

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
module tb_peripheral_spram_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int BW = DW / 8;
`ifdef PERIPHERAL_SPRAM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic [BW-1:0] m0_be_i = '0;
  logic [DW-1:0] m0_data_i = '0;
  logic          m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [BW-1:0] m1_be_i = '0;
  logic [DW-1:0] m1_data_i = '0;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          req_o, we_o;
  logic [AW-1:0] addr_o;
  logic [BW-1:0] be_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_i = '0;

  always #5 HCLK = ~HCLK;

  peripheral_spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i), .m0_data_i(m0_data_i),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i), .m1_data_i(m1_data_i),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
    .data_o(data_o), .data_i(data_i)
  );

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < BW; b++)
      if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // SPRAM macro behaviour: one-cycle read latency, byte-enabled writes.
  logic [DW-1:0] spram [256];
  always @(posedge HCLK) begin
    if (req_o) begin
      if (we_o)
        spram[addr_o[7:0]] <= (spram[addr_o[7:0]] & ~be_mask(be_o)) | (data_o & be_mask(be_o));
      else
        data_i <= spram[addr_o[7:0]];
    end
  end

  // Reference model: memory image as seen by the requesters, expected port
  // command, and a list of reads with the cycle their data must appear.
  typedef struct {
    int          due;
    bit          id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] ref_mem [256];
  bit            m_last;
  logic          e_req, e_we;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_data;
  bit            g0_prev, g1_prev;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_last = 1'b1;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_data = '0;
    g0_prev = 1'b0; g1_prev = 1'b0;
  endtask

  // One clock cycle: check everything at the falling edge, then advance the
  // model as the rising edge will; returns 1ns after that rising edge.
  task automatic tick();
    bit tie, win, g0, g1, any, rv0, rv1, w_we;
    logic [AW-1:0] w_addr;
    logic [BW-1:0] w_be;
    logic [DW-1:0] w_data, rd;
    @(negedge HCLK);
    tie = m0_req_i && m1_req_i;
    if (tie) win = RR ? !m_last : 1'b1;
    else     win = m1_req_i;
    any = m0_req_i || m1_req_i;
    g0 = any && !win;
    g1 = any && win;
    chk("m0_gnt", m0_gnt_o, g0);
    chk("m1_gnt", m1_gnt_o, g1);
    chk("req_o", req_o, e_req);
    chk("we_o", we_o, e_we);
    chk("addr_o", addr_o, e_addr);
    chk("be_o", be_o, e_be);
    chk("data_o", data_o, e_data);
    rv0 = 0; rv1 = 0; rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rv0 = !pend[0].id;
      rv1 = pend[0].id;
      rd  = pend[0].data;
      void'(pend.pop_front());
    end
    chk("m0_rvalid", m0_rvalid_o, rv0);
    chk("m1_rvalid", m1_rvalid_o, rv1);
    if (rv0) chk("m0_rdata", m0_rdata_o, rd);
    if (rv1) chk("m1_rdata", m1_rdata_o, rd);

    e_req = any;
    if (any) begin
      w_we   = win ? m1_we_i   : m0_we_i;
      w_addr = win ? m1_addr_i : m0_addr_i;
      w_be   = win ? m1_be_i   : m0_be_i;
      w_data = win ? m1_data_i : m0_data_i;
      e_we = w_we; e_addr = w_addr; e_be = w_be; e_data = w_data;
      m_last = win;
      if (w_we)
        ref_mem[w_addr[7:0]] = (ref_mem[w_addr[7:0]] & ~be_mask(w_be)) | (w_data & be_mask(w_be));
      else
        pend.push_back('{due: cyc + 2, id: win, data: ref_mem[w_addr[7:0]]});
    end
    g0_prev = g0;
    g1_prev = g1;
    cyc++;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_random();
    if (!m0_req_i || g0_prev) begin
      m0_req_i  = ($urandom_range(0, 3) != 0);
      m0_we_i   = $urandom_range(0, 1);
      m0_addr_i = $urandom;
      m0_be_i   = BW'($urandom);
      m0_data_i = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) m0_req_i = 1'b0;
    if (!m1_req_i || g1_prev) begin
      m1_req_i  = ($urandom_range(0, 3) != 0);
      m1_we_i   = $urandom_range(0, 1);
      m1_addr_i = $urandom;
      m1_be_i   = BW'($urandom);
      m1_data_i = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) m1_req_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      spram[i]   = DW'($urandom);
      ref_mem[i] = spram[i];
    end
    spram[8'h10]   = 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;
    model_reset();

    // Reset state
    tick(); tick();
    HRESET = 1'b0;
    tick();

    // Single read by m0 at 0x10
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
    tick();
    m0_req_i = 0;
    tick(); tick(); tick();

    // m1 write 0xA5A5 to 0x4, then read it back
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h4; m1_be_i = 2'b11; m1_data_i = 16'hA5A5;
    tick();
    m1_we_i = 0; m1_data_i = '0;
    tick();
    m1_req_i = 0;
    tick(); tick(); tick();

    // Tie: both read continuously for 6 cycles, then m1 drops out
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h20;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h30;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (g0_prev) m0_addr_i = m0_addr_i + 1;
      if (g1_prev) m1_addr_i = m1_addr_i + 1;
    end
    m1_req_i = 0;
    tick();
    m0_req_i = 0;
    tick(); tick(); tick();

    // Back-to-back: m0 read then m1 read
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h55;
    tick();
    m0_req_i = 0;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h66;
    tick();
    m1_req_i = 0;
    tick(); tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end

    // Reset with two reads in flight
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h77; m1_req_i = 0;
    tick();
    m0_req_i = 0;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h88;
    tick();
    m1_req_i = 0;
    HRESET = 1'b1;
    #1;
    chk("rst_req_o", req_o, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid_o, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid_o, 1'b0);
    model_reset();
    tick(); tick();
    HRESET = 1'b0;
    tick(); tick(); tick();

    // More random traffic after reset
    for (int i = 0; i < 300; i++) begin
      drive_random();
      tick();
    end
    m0_req_i = 0; m1_req_i = 0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
